// File: rtl/npc_ctrl_pkg.sv
// Shared definitions for the next-PC controller: branch type and FSM state
// encodings plus the ALU compare-true constant.
package npc_ctrl_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_type_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_REDIR = 2'd3
  } state_t;

  localparam logic [31:0] ALU_TRUE = 32'd1;

  // JALR targets are always halfword aligned.
  function automatic logic [31:0] clr_lsb(input logic [31:0] a);
    return a & ~32'd1;
  endfunction

endpackage

// File: rtl/npc_ctrl_if.sv
// Bus between the next-PC controller (master) and the fetch/execute pipeline (slave).
// Handshake: a fetch of pc completes on a cycle with pc_valid && if_ready && !stall;
// until then pc holds steady. ex_valid qualifies br_type/ex_pc/imm/rs1/alu_c/alu_zero.
interface npc_ctrl_if;
  import npc_ctrl_pkg::*;

  logic        ex_valid;
  br_type_t    br_type;
  logic [31:0] ex_pc;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] alu_c;
  logic        alu_zero;
  logic        stall;
  logic        if_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        taken;

  modport master (
    input  ex_valid, br_type, ex_pc, imm, rs1, alu_c, alu_zero, stall, if_ready,
    output pc, pc_valid, flush, taken
  );

  modport slave (
    output ex_valid, br_type, ex_pc, imm, rs1, alu_c, alu_zero, stall, if_ready,
    input  pc, pc_valid, flush, taken
  );
endinterface

// File: rtl/npc_ctrl_br_decide.sv
// Combinational branch resolution: taken decision and redirect target.
module br_decide
  import npc_ctrl_pkg::*;
(
  input  br_type_t    br_type,
  input  logic [31:0] alu_c,
  input  logic        alu_zero,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic        take,
  output logic [31:0] target
);

  // alu_zero already encodes every compare outcome, so alu_c is not consulted.
  logic unused_alu_c;
  assign unused_alu_c = |alu_c;

  always_comb begin
    take   = 1'b0;
    target = ex_pc + imm;
    case (br_type)
      BR_BEQ:  take = alu_zero;
      BR_BNE,
      BR_BLT,
      BR_BGE,
      BR_BLTU,
      BR_BGEU: take = ~alu_zero;
      BR_JAL:  take = 1'b1;
      BR_JALR: begin
        take   = 1'b1;
        target = clr_lsb(rs1 + imm);
      end
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_ctrl.sv
// Next-PC controller: sequential fetch, redirect with flush bubbles, stall hold.
// Optional NPC_BR_STATS_EN adds resolved/taken branch counters.
module npc_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          REDIRECT_BUBBLES = 1
) (
  input  logic       clk,
  input  logic       rstn,
  npc_ctrl_if.master bus,
  output state_t     state
`ifdef NPC_BR_STATS_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt
`endif
);

  localparam logic [1:0] BUB_LAST = 2'(REDIRECT_BUBBLES - 1);

  state_t      state_q;
  logic [31:0] pc_q;
  logic        pc_valid_q;
  logic        flush_q;
  logic        taken_q;
  logic [1:0]  bub_q;

  logic        take;
  logic [31:0] target;
  logic        resolve;

  br_decide u_br_decide (
    .br_type  (bus.br_type),
    .alu_c    (bus.alu_c),
    .alu_zero (bus.alu_zero),
    .ex_pc    (bus.ex_pc),
    .imm      (bus.imm),
    .rs1      (bus.rs1),
    .take     (take),
    .target   (target)
  );

  assign resolve = bus.ex_valid && !bus.stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      taken_q    <= 1'b0;
      bub_q      <= 2'd0;
    end else begin
      if (resolve) taken_q <= take;
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
        // Leaving HOLD behaves like RUN so a re-presented redirect or a
        // completing fetch handshake is honoured on the release cycle.
        ST_RUN, ST_HOLD: begin
          if (bus.stall) begin
            state_q <= ST_HOLD;
          end else if (bus.ex_valid && take) begin
            state_q    <= ST_REDIR;
            pc_q       <= target;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b1;
            bub_q      <= BUB_LAST;
          end else begin
            state_q <= ST_RUN;
            if (pc_valid_q && bus.if_ready) pc_q <= pc_q + 32'd4;
          end
        end
        ST_REDIR: begin
          if (!bus.stall) begin
            if (bub_q == 2'd0) begin
              state_q    <= ST_RUN;
              pc_valid_q <= 1'b1;
              flush_q    <= 1'b0;
            end else begin
              bub_q <= bub_q - 2'd1;
            end
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.flush    = flush_q;
  assign bus.taken    = taken_q;
  assign state        = state_q;

`ifdef NPC_BR_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_cnt       <= 32'd0;
      br_taken_cnt <= 32'd0;
    end else if (resolve && bus.br_type != BR_NONE) begin
      br_cnt <= br_cnt + 32'd1;
      if (take) br_taken_cnt <= br_taken_cnt + 32'd1;
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// Table-driven bench for npc_ctrl plus hand sequences for reset-in-redirect
// and multi-bubble flush length (second instance with REDIRECT_BUBBLES = 3).
module tb_npc_ctrl;
  import npc_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rstn = 1'b0;
  state_t st1, st3;
  int     n_tests = 0;
  int     n_fail  = 0;

  always #5 clk = ~clk;

  npc_ctrl_if bus1 ();
  npc_ctrl_if bus3 ();

`ifdef NPC_BR_STATS_EN
  logic [31:0] brc1, brt1, brc3, brt3;
`endif

  npc_ctrl #(.RESET_PC(32'h0000_0000), .REDIRECT_BUBBLES(1)) dut1 (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus1),
    .state (st1)
`ifdef NPC_BR_STATS_EN
    ,
    .br_cnt       (brc1),
    .br_taken_cnt (brt1)
`endif
  );

  npc_ctrl #(.RESET_PC(32'h0000_0100), .REDIRECT_BUBBLES(3)) dut3 (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus3),
    .state (st3)
`ifdef NPC_BR_STATS_EN
    ,
    .br_cnt       (brc3),
    .br_taken_cnt (brt3)
`endif
  );

  typedef struct {
    string       name;
    logic        ev;
    br_type_t    bt;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] alu_c;
    logic        zero;
    logic        stall;
    logic        rdy;
    logic [31:0] e_pc;
    logic        e_pv;
    logic        e_fl;
    logic        e_tk;
    state_t      e_st;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic ev, input br_type_t bt,
                     input logic [31:0] ex_pc, input logic [31:0] imm,
                     input logic [31:0] rs1, input logic [31:0] alu_c,
                     input logic zero, input logic stall, input logic rdy,
                     input logic [31:0] e_pc, input logic e_pv, input logic e_fl,
                     input logic e_tk, input state_t e_st);
    vec_t v;
    v.name = name; v.ev = ev; v.bt = bt; v.ex_pc = ex_pc; v.imm = imm;
    v.rs1 = rs1; v.alu_c = alu_c; v.zero = zero; v.stall = stall; v.rdy = rdy;
    v.e_pc = e_pc; v.e_pv = e_pv; v.e_fl = e_fl; v.e_tk = e_tk; v.e_st = e_st;
    vq.push_back(v);
  endtask

  task automatic set_in(input logic ev, input br_type_t bt, input logic [31:0] ex_pc,
                        input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [31:0] alu_c, input logic zero,
                        input logic stall, input logic rdy);
    bus1.ex_valid = ev; bus1.br_type = bt; bus1.ex_pc = ex_pc; bus1.imm = imm;
    bus1.rs1 = rs1; bus1.alu_c = alu_c; bus1.alu_zero = zero;
    bus1.stall = stall; bus1.if_ready = rdy;
    bus3.ex_valid = ev; bus3.br_type = bt; bus3.ex_pc = ex_pc; bus3.imm = imm;
    bus3.rs1 = rs1; bus3.alu_c = alu_c; bus3.alu_zero = zero;
    bus3.stall = stall; bus3.if_ready = rdy;
  endtask

  task automatic idle();
    set_in(1'b0, BR_NONE, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int flush_len;

    // ---- vector table (dut1: RESET_PC = 0, one bubble) ----
    //  name          ev    type     ex_pc         imm           rs1           alu_c  z     stall rdy   e_pc          pv    fl    tk    state
    add("boot_run",   1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, ST_RUN);
    add("seq_4",      1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h4,        1'b1, 1'b0, 1'b0, ST_RUN);
    add("seq_8",      1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h8,        1'b1, 1'b0, 1'b0, ST_RUN);
    add("bne_nt",     1'b1, BR_BNE,  32'h40,       32'h10,       32'h0,        32'd0, 1'b1, 1'b0, 1'b1, 32'hC,        1'b1, 1'b0, 1'b0, ST_RUN);
    add("beq_t",      1'b1, BR_BEQ,  32'h40,       32'h10,       32'h0,        32'd0, 1'b1, 1'b0, 1'b1, 32'h50,       1'b0, 1'b1, 1'b1, ST_REDIR);
    add("beq_run",    1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h50,       1'b1, 1'b0, 1'b1, ST_RUN);
    add("seq_54",     1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h54,       1'b1, 1'b0, 1'b1, ST_RUN);
    add("not_ready",  1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b0, 32'h54,       1'b1, 1'b0, 1'b1, ST_RUN);
    add("jalr_t",     1'b1, BR_JALR, 32'h200,      32'h2,        32'h101,      32'd0, 1'b0, 1'b0, 1'b1, 32'h102,      1'b0, 1'b1, 1'b1, ST_REDIR);
    add("jalr_run",   1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h102,      1'b1, 1'b0, 1'b1, ST_RUN);
    add("blt_back",   1'b1, BR_BLT,  32'h80,       32'hFFFF_FFF0,32'h0,        32'd1, 1'b0, 1'b0, 1'b1, 32'h70,       1'b0, 1'b1, 1'b1, ST_REDIR);
    add("blt_run",    1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h70,       1'b1, 1'b0, 1'b1, ST_RUN);
    add("bgeu_nt",    1'b1, BR_BGEU, 32'h300,      32'h40,       32'h0,        32'd0, 1'b1, 1'b0, 1'b1, 32'h74,       1'b1, 1'b0, 1'b0, ST_RUN);
    add("jal_wrap",   1'b1, BR_JAL,  32'hFFFF_FFF0,32'h20,       32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h10,       1'b0, 1'b1, 1'b1, ST_REDIR);
    add("jal_run",    1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h10,       1'b1, 1'b0, 1'b1, ST_RUN);
    add("beq_misal",  1'b1, BR_BEQ,  32'h10,       32'h2,        32'h0,        32'd0, 1'b1, 1'b0, 1'b1, 32'h12,       1'b0, 1'b1, 1'b1, ST_REDIR);
    add("misal_run",  1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h12,       1'b1, 1'b0, 1'b1, ST_RUN);
    add("none_nt",    1'b1, BR_NONE, 32'h500,      32'h8,        32'h0,        32'd0, 1'b1, 1'b0, 1'b1, 32'h16,       1'b1, 1'b0, 1'b0, ST_RUN);
    add("stall_1",    1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b1, 1'b1, 32'h16,       1'b1, 1'b0, 1'b0, ST_HOLD);
    add("stall_2",    1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b1, 1'b1, 32'h16,       1'b1, 1'b0, 1'b0, ST_HOLD);
    add("stall_3_ex", 1'b1, BR_BEQ,  32'h40,       32'h10,       32'h0,        32'd0, 1'b1, 1'b1, 1'b1, 32'h16,       1'b1, 1'b0, 1'b0, ST_HOLD);
    add("unstall",    1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h1A,       1'b1, 1'b0, 1'b0, ST_RUN);
    add("seq_1e",     1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h1E,       1'b1, 1'b0, 1'b0, ST_RUN);
    add("hold_bne",   1'b1, BR_BNE,  32'h100,      32'h8,        32'h0,        32'd5, 1'b0, 1'b1, 1'b1, 32'h1E,       1'b1, 1'b0, 1'b0, ST_HOLD);
    add("rep_bne",    1'b1, BR_BNE,  32'h100,      32'h8,        32'h0,        32'd5, 1'b0, 1'b0, 1'b1, 32'h108,      1'b0, 1'b1, 1'b1, ST_REDIR);
    add("rep_run",    1'b0, BR_NONE, 32'h0,        32'h0,        32'h0,        32'd0, 1'b0, 1'b0, 1'b1, 32'h108,      1'b1, 1'b0, 1'b1, ST_RUN);

    // ---- reset ----
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",     bus1.pc, 32'h0);
    chk("rst_pv",     32'(bus1.pc_valid), 32'd0);
    chk("rst_flush",  32'(bus1.flush), 32'd0);
    chk("rst_taken",  32'(bus1.taken), 32'd0);
    chk("rst_state",  32'(st1), 32'(ST_BOOT));
    chk("rst_pc3",    bus3.pc, 32'h100);
    rstn = 1'b1;
    #1;
    chk("boot_pv",    32'(bus1.pc_valid), 32'd0);

    // ---- vector loop ----
    foreach (vq[i]) begin
      set_in(vq[i].ev, vq[i].bt, vq[i].ex_pc, vq[i].imm, vq[i].rs1,
             vq[i].alu_c, vq[i].zero, vq[i].stall, vq[i].rdy);
      tick();
      chk({vq[i].name, ".pc"},    bus1.pc, vq[i].e_pc);
      chk({vq[i].name, ".pv"},    32'(bus1.pc_valid), 32'(vq[i].e_pv));
      chk({vq[i].name, ".flush"}, 32'(bus1.flush), 32'(vq[i].e_fl));
      chk({vq[i].name, ".taken"}, 32'(bus1.taken), 32'(vq[i].e_tk));
      chk({vq[i].name, ".state"}, 32'(st1), 32'(vq[i].e_st));
    end
`ifdef NPC_BR_STATS_EN
    chk("stats_br",    brc1, 32'd8);
    chk("stats_taken", brt1, 32'd6);
`endif

    // ---- reset in the middle of a 3-bubble redirect (dut3) ----
    idle();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
    chk("r3_run_pc", bus3.pc, 32'h100);
    set_in(1'b1, BR_BEQ, 32'h40, 32'h10, 32'h0, 32'd0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("r3_redir_pc", bus3.pc, 32'h50);
    chk("r3_redir_fl", 32'(bus3.flush), 32'd1);
    idle();
    tick();
    chk("r3_mid_fl",    32'(bus3.flush), 32'd1);
    chk("r3_mid_state", 32'(st3), 32'(ST_REDIR));
    rstn = 1'b0;
    #1;
    chk("r3_async_pc",    bus3.pc, 32'h100);
    chk("r3_async_fl",    32'(bus3.flush), 32'd0);
    chk("r3_async_pv",    32'(bus3.pc_valid), 32'd0);
    chk("r3_async_state", 32'(st3), 32'(ST_BOOT));
    #2;
    rstn = 1'b1;
    tick();
    chk("r3_after_pc",    bus3.pc, 32'h100);
    chk("r3_after_pv",    32'(bus3.pc_valid), 32'd1);
    chk("r3_after_fl",    32'(bus3.flush), 32'd0);

    // ---- flush length with three bubbles ----
    set_in(1'b1, BR_JAL, 32'h200, 32'h20, 32'h0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    flush_len = bus3.flush ? 1 : 0;
    for (int i = 0; i < 8 && bus3.flush; i++) begin
      tick();
      if (bus3.flush) flush_len++;
    end
    chk("r3_flush_len",  32'(flush_len), 32'd3);
    chk("r3_resume_pc",  bus3.pc, 32'h220);
    chk("r3_resume_pv",  32'(bus3.pc_valid), 32'd1);
    tick();
    chk("r3_seq_pc",     bus3.pc, 32'h224);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_ctrl.md
NPC_CTRL -- requirements
Module: npc_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter REDIRECT_BUBBLES, 1, flush cycles after a taken redirect (legal 1..3).
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 ex_valid  input  1  instruction in execute carries a valid branch/jump decision this cycle.
REQ-006 br_type  input  4  NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR.
REQ-007 ex_pc  input  32  PC of the executing instruction.
REQ-008 imm  input  32  sign-extended branch/jump offset.
REQ-009 rs1  input  32  JALR base register.
REQ-010 alu_c  input  32  ALU result; compare ops return 32'd1 for true, 32'd0 for false.
REQ-011 alu_zero  input  1  ALU zero flag (alu_c == 0).
REQ-012 stall  input  1  pipeline hold; freezes PC and state.
REQ-013 if_ready  input  1  fetch accepts pc this cycle.
REQ-014 pc  output  32  fetch address.
REQ-015 pc_valid  output  1  pc is a valid fetch request.
REQ-016 flush  output  1  kill younger in-flight instructions.
REQ-017 taken  output  1  registered: last resolved branch was taken.

Function
REQ-018 Taken decision: BEQ = alu_zero; BNE/BLT/BGE/BLTU/BGEU = ~alu_zero; JAL/JALR = 1; NONE = 0.
REQ-019 Targets: branch/JAL = ex_pc + imm; JALR = (rs1 + imm) & ~32'd1; 32-bit wrap-around, no overflow flag.
REQ-020 States: BOOT, RUN, HOLD, REDIR; encoded in the shared package.
REQ-021 BOOT: one cycle after reset release, pc = RESET_PC, pc_valid = 0; always goes to RUN.
REQ-022 RUN: pc_valid = 1; pc <= pc + 4 on the cycle with pc_valid && if_ready && !stall.
REQ-023 RUN with ex_valid && taken-decision && !stall: pc <= target, flush = 1 in the same cycle, go to REDIR.
REQ-024 REDIR: pc_valid = 0, flush = 1 for REDIRECT_BUBBLES cycles (counter), then RUN with pc = target.
REQ-025 stall = 1 in RUN: go to HOLD; pc, pc_valid and counter are frozen; ex_valid is ignored.
REQ-026 HOLD: returns to RUN on the first cycle stall = 0; a redirect is never lost, because the executing instruction is re-presented.
REQ-027 Simultaneous redirect and if_ready: redirect wins; sequential pc + 4 is discarded.
REQ-028 Redirect arriving in REDIR: ignored; ex_valid is guaranteed low under flush.
REQ-029 pc misaligned (bits[1:0] != 0) after a branch target: pc is forwarded unchanged; no exception is raised in this block.
REQ-030 taken updates only on ex_valid && !stall; otherwise it holds its value.
REQ-031 Latency: target appears on pc exactly one cycle after the deciding ex_valid edge.

Reset
REQ-032 rstn low asynchronously forces pc = RESET_PC, pc_valid = 0, flush = 0, taken = 0, state = BOOT, counter = 0.
REQ-033 Reset asserted mid-REDIR aborts the bubble count; no pending target survives reset.

Configuration
REQ-034 Macro NPC_BR_STATS_EN: when defined, adds 32-bit outputs br_cnt and br_taken_cnt, counting resolved non-NONE decisions and taken ones; both wrap at 2^32 and reset to 0.
REQ-035 Without NPC_BR_STATS_EN: neither the ports nor the counters exist, and the remaining behaviour is identical.

Structure
REQ-036 A shared package holds the br_type encoding, the FSM state encoding and the ALU compare-true constant (32'd1).
REQ-037 One sub-module, br_decide, is combinational: br_type, alu_c, alu_zero, operands -> take, target.

Verification
REQ-038 Reset release with RESET_PC = 0, if_ready = 1 -> pc_valid 0 for one cycle, then pc = 0, 4, 8.
REQ-039 BEQ with alu_zero = 1, ex_pc = 0x40, imm = 0x10 -> flush for 1 cycle, then pc = 0x50, taken = 1.
REQ-040 BNE with alu_c = 0 (alu_zero = 1) -> no flush, pc continues +4, taken = 0.
REQ-041 JALR with rs1 = 0x101, imm = 0x2 -> pc = 0x102 (LSB cleared), flush asserted.
REQ-042 stall held 3 cycles in RUN with if_ready = 1 -> pc constant; resumes +4 after release.
REQ-043 rstn pulsed low during REDIR (REDIRECT_BUBBLES = 3) -> pc = RESET_PC immediately, flush = 0, state = BOOT.
